// File: rtl/rv_opcodes_pkg.sv
// rv_opcodes_pkg: RISC-V major-opcode indexes (opcode[6:2]), instruction
// format enum and the index-to-format mapping shared by encoder and decoders.
package rv_opcodes_pkg;

  localparam logic [4:0] LOAD      = 5'd0;
  localparam logic [4:0] LOAD_FP   = 5'd1;
  localparam logic [4:0] MISC_MEM  = 5'd3;
  localparam logic [4:0] OP_IMM    = 5'd4;
  localparam logic [4:0] AUIPC     = 5'd5;
  localparam logic [4:0] OP_IMM_32 = 5'd6;
  localparam logic [4:0] STORE     = 5'd8;
  localparam logic [4:0] STORE_FP  = 5'd9;
  localparam logic [4:0] AMO       = 5'd11;
  localparam logic [4:0] OP        = 5'd12;
  localparam logic [4:0] LUI       = 5'd13;
  localparam logic [4:0] OP_32     = 5'd14;
  localparam logic [4:0] MADD      = 5'd16;
  localparam logic [4:0] MSUB      = 5'd17;
  localparam logic [4:0] NMSUB     = 5'd18;
  localparam logic [4:0] NMADD     = 5'd19;
  localparam logic [4:0] OP_FP     = 5'd20;
  localparam logic [4:0] BRANCH    = 5'd24;
  localparam logic [4:0] JALR      = 5'd25;
  localparam logic [4:0] JAL       = 5'd27;
  localparam logic [4:0] SYSTEM    = 5'd28;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_R4,
    FMT_ILL
  } fmt_e;

  // Any index without a defined major opcode maps to FMT_ILL.
  function automatic fmt_e index_to_fmt(input logic [4:0] idx);
    fmt_e fmt;
    case (idx)
      LOAD, LOAD_FP, MISC_MEM, OP_IMM, OP_IMM_32, JALR, SYSTEM: fmt = FMT_I;
      STORE, STORE_FP:                                          fmt = FMT_S;
      BRANCH:                                                   fmt = FMT_B;
      AUIPC, LUI:                                               fmt = FMT_U;
      JAL:                                                      fmt = FMT_J;
      AMO, OP, OP_32, OP_FP:                                    fmt = FMT_R;
      MADD, MSUB, NMSUB, NMADD:                                 fmt = FMT_R4;
      default:                                                  fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and result channels of the instruction encoder.
// The master side issues requests and consumes encoded words; the slave side
// is the encoder itself.
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] code;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rs3;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        illegal;
  logic [15:0] illegal_count;

  modport master (
    output in_valid, code, rd, rs1, rs2, rs3, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, illegal, illegal_count
  );

  modport slave (
    input  in_valid, code, rd, rs1, rs2, rs3, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, illegal, illegal_count
  );

endinterface

// File: rtl/instr_encoder_onehot_to_index.sv
// onehot_to_index: combinational one-hot to binary index conversion, with a
// flag that is high only when exactly one input bit is set.
module onehot_to_index (
  input  logic [31:0] onehot_i,
  output logic [4:0]  index_o,
  output logic        valid_onehot_o
);

  // OR together the positions of all set bits; exact for a true one-hot input.
  always_comb begin
    index_o = '0;
    for (int n = 0; n < 32; n++) begin
      if (onehot_i[n]) begin
        index_o = index_o | 5'(n);
      end
    end
  end

  // x & (x-1) clears the lowest set bit, so it is zero only for zero or one set bit.
  assign valid_onehot_o = (onehot_i != 32'd0) &&
                          ((onehot_i & (onehot_i - 32'd1)) == 32'd0);

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready pipeline turning a one-hot opcode class
// plus register/immediate fields into a 32-bit RISC-V instruction word.
// S1 holds the request with its decoded index and format; S2 holds the
// formatted word. Illegal requests flow through as a zero word with illegal=1.
module instr_encoder
  import rv_opcodes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);

  logic [4:0]  decIndex;
  logic        decOneHot;
  fmt_e        decFmt;

  logic        s1Valid_q;
  fmt_e        s1Fmt_q;
  logic [4:0]  s1Index_q;
  logic [4:0]  s1Rd_q;
  logic [4:0]  s1Rs1_q;
  logic [4:0]  s1Rs2_q;
  logic [4:0]  s1Rs3_q;
  logic [2:0]  s1Funct3_q;
  logic [6:0]  s1Funct7_q;
  logic [31:0] s1Imm_q;

  logic        s2Valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic        illegal_q;
  logic        illegal_d;
  logic [15:0] illegalCount_q;
  logic [15:0] illegalCount_d;
  logic [6:0]  opcode;

  logic        s2Advance;
  logic        inFire;
  logic        outFire;

  onehot_to_index u_onehotToIndex (
    .onehot_i       (bus.code),
    .index_o        (decIndex),
    .valid_onehot_o (decOneHot)
  );

  // Non-one-hot codes and unlisted indexes share FMT_ILL so later logic has one illegal case.
  assign decFmt = decOneHot ? index_to_fmt(decIndex) : FMT_ILL;

  // S2 can take a new word when it is empty or its word leaves this cycle.
  assign s2Advance     = !s2Valid_q || bus.out_ready;
  assign bus.in_ready  = !s1Valid_q || s2Advance;
  assign inFire        = bus.in_valid && bus.in_ready;
  assign outFire       = s2Valid_q && bus.out_ready;

  assign bus.out_valid     = s2Valid_q;
  assign bus.instr         = instr_q;
  assign bus.illegal       = illegal_q;
  assign bus.illegal_count = illegalCount_q;

  // S1 occupancy: refilled (or emptied) whenever the stage may accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
    end else if (bus.in_ready) begin
      s1Valid_q <= bus.in_valid;
    end
  end

  // S1 payload is only meaningful while s1Valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (inFire) begin
      s1Fmt_q    <= decFmt;
      s1Index_q  <= decIndex;
      s1Rd_q     <= bus.rd;
      s1Rs1_q    <= bus.rs1;
      s1Rs2_q    <= bus.rs2;
      s1Rs3_q    <= bus.rs3;
      s1Funct3_q <= bus.funct3;
      s1Funct7_q <= bus.funct7;
      s1Imm_q    <= bus.imm;
    end
  end

  // Pack S1 fields into the word for its format; illegal requests give all zeros.
  always_comb begin
    opcode    = {s1Index_q, 2'b11};
    instr_d   = 32'h0;
    illegal_d = 1'b0;
    case (s1Fmt_q)
      FMT_I:  instr_d = {s1Imm_q[11:0], s1Rs1_q, s1Funct3_q, s1Rd_q, opcode};
      FMT_S:  instr_d = {s1Imm_q[11:5], s1Rs2_q, s1Rs1_q, s1Funct3_q,
                         s1Imm_q[4:0], opcode};
      FMT_B:  instr_d = {s1Imm_q[12], s1Imm_q[10:5], s1Rs2_q, s1Rs1_q,
                         s1Funct3_q, s1Imm_q[4:1], s1Imm_q[11], opcode};
      FMT_U:  instr_d = {s1Imm_q[31:12], s1Rd_q, opcode};
      FMT_J:  instr_d = {s1Imm_q[20], s1Imm_q[10:1], s1Imm_q[11],
                         s1Imm_q[19:12], s1Rd_q, opcode};
      FMT_R:  instr_d = {s1Funct7_q, s1Rs2_q, s1Rs1_q, s1Funct3_q, s1Rd_q, opcode};
      FMT_R4: instr_d = {s1Rs3_q, s1Funct7_q[1:0], s1Rs2_q, s1Rs1_q,
                         s1Funct3_q, s1Rd_q, opcode};
      default: begin
        instr_d   = 32'h0;
        illegal_d = 1'b1;
      end
    endcase
  end

  // S2 output register; word and flag only change when a new word is loaded,
  // so they hold steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      instr_q   <= 32'h0;
      illegal_q <= 1'b0;
    end else if (s2Advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        instr_q   <= instr_d;
        illegal_q <= illegal_d;
      end
    end
  end

  // Count only illegal words actually handed over, sticking at the maximum.
  always_comb begin
    illegalCount_d = illegalCount_q;
    if (outFire && illegal_q && (illegalCount_q != 16'hFFFF)) begin
      illegalCount_d = illegalCount_q + 16'd1;
    end
  end

  // Illegal-request counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegalCount_q <= 16'h0;
    end else begin
      illegalCount_q <= illegalCount_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomised checks of the instruction encoder
// with a queue of expected words consumed by an output monitor.
module tb_instr_encoder;

  typedef struct packed {
    logic [31:0] code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  logic clk = 1'b0;
  logic rst;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cyc        = 0;
  bit randomReady = 1'b0;
  logic [32:0] expQ[$];
  int outCycles[$];

  // Cycle counter for spacing checks.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t makeReq(input logic [31:0] code, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rs3, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.code = code; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.rs3 = rs3;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  // Reference encoder written from the instruction-format tables: {illegal, word}.
  function automatic logic [32:0] refEncode(input req_t r);
    int idx;
    logic [6:0] op;
    if ($countones(r.code) != 1) return {1'b1, 32'h0};
    idx = 0;
    for (int i = 0; i < 32; i++) if (r.code[i]) idx = i;
    op = {idx[4:0], 2'b11};
    case (idx)
      0, 1, 3, 4, 6, 25, 28: return {1'b0, r.imm[11:0], r.rs1, r.f3, r.rd, op};
      8, 9:                  return {1'b0, r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], op};
      24:                    return {1'b0, r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3,
                                     r.imm[4:1], r.imm[11], op};
      5, 13:                 return {1'b0, r.imm[31:12], r.rd, op};
      27:                    return {1'b0, r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12],
                                     r.rd, op};
      11, 12, 14, 20:        return {1'b0, r.f7, r.rs2, r.rs1, r.f3, r.rd, op};
      16, 17, 18, 19:        return {1'b0, r.rs3, r.f7[1:0], r.rs2, r.rs1, r.f3, r.rd, op};
      default:               return {1'b1, 32'h0};
    endcase
  endfunction

  // Output monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      outCycles.push_back(cyc);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("instr", bus.instr, e[31:0]);
        checkOutput("illegal", {31'd0, bus.illegal}, {31'd0, e[32]});
      end
    end
  end

  task automatic driveReq(input req_t r);
    bus.in_valid = 1'b1;
    bus.code = r.code; bus.rd = r.rd; bus.rs1 = r.rs1; bus.rs2 = r.rs2;
    bus.rs3 = r.rs3; bus.funct3 = r.f3; bus.funct7 = r.f7; bus.imm = r.imm;
  endtask

  // Wait (bounded) for the pending request to be accepted, then queue its expected result.
  task automatic waitAccept(input logic [32:0] expWord);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      if (randomReady) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) expQ.push_back(expWord);
    else checkOutput("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (randomReady) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input req_t r, input logic [32:0] expWord);
    driveReq(r);
    waitAccept(expWord);
  endtask

  task automatic waitDrain();
    int n = 0;
    randomReady   = 1'b0;
    bus.out_ready = 1'b1;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
  endtask

  initial begin
    req_t r;
    req_t ra;
    logic [32:0] expA;
    logic [31:0] c;
    int a;
    int b;
    int sel;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.code = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.rs3 = '0;
    bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_instr", bus.instr, 32'd0);
    checkOutput("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    checkOutput("rst_count", {16'd0, bus.illegal_count}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("[TB] ADDI latency");
    applyStimulus(makeReq(32'h1 << 4, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5),
                  {1'b0, 32'h00500093});
    checkOutput("addi_lat1_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("addi_lat2_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("addi_lat2_instr", bus.instr, 32'h00500093);
    waitDrain();

    $display("[TB] format mix back-to-back");
    outCycles.delete();
    applyStimulus(makeReq(32'h1 << 13, 5'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000),
                  {1'b0, 32'h12345137});
    applyStimulus(makeReq(32'h1 << 24, 5'd0, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8),
                  {1'b0, 32'h00208463});
    applyStimulus(makeReq(32'h1 << 27, 5'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16),
                  {1'b0, 32'h010000EF});
    applyStimulus(makeReq(32'h1 << 12, 5'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0),
                  {1'b0, 32'h002081B3});
    waitDrain();
    checkOutput("mix_count", 32'(outCycles.size()), 32'd4);
    for (int i = 1; i < outCycles.size(); i++)
      checkOutput("mix_spacing", 32'(outCycles[i] - outCycles[i-1]), 32'd1);

    $display("[TB] illegal codes");
    applyStimulus(makeReq(32'h0, 5'd1, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'hFFFF), {1'b1, 32'h0});
    applyStimulus(makeReq(32'h3, 5'd1, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'hFFFF), {1'b1, 32'h0});
    applyStimulus(makeReq(32'h1 << 2, 5'd1, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'hFFFF), {1'b1, 32'h0});
    waitDrain();
    checkOutput("illegal_count3", {16'd0, bus.illegal_count}, 32'd3);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    ra   = makeReq(32'h1 << 8, 5'd0, 5'd2, 5'd5, 5'd0, 3'd2, 7'd0, 32'hFFFFFFF4);
    expA = refEncode(ra);
    applyStimulus(ra, expA);
    r = makeReq(32'h1 << 16, 5'd7, 5'd8, 5'd9, 5'd10, 3'd7, 7'h2B, 32'd0);
    applyStimulus(r, refEncode(r));
    r = makeReq(32'h1 << 5, 5'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE123);
    driveReq(r);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("bp_hold_instr", bus.instr, expA[31:0]);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    waitAccept(refEncode(r));
    waitDrain();

    $display("[TB] reset mid-flight");
    applyStimulus(makeReq(32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), {1'b1, 32'h0});
    applyStimulus(makeReq(32'h1 << 4, 5'd9, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1),
                  {1'b0, 32'h00148493});
    applyReset();
    checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst_count", {16'd0, bus.illegal_count}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] random mix with random out_ready");
    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        c = 32'h0;
      end else if (sel == 1) begin
        a = $urandom_range(0, 31);
        b = (a + $urandom_range(1, 31)) % 32;
        c = (32'h1 << a) | (32'h1 << b);
      end else begin
        c = 32'h1 << $urandom_range(0, 31);
      end
      r = makeReq(c, 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                  3'($urandom()), 7'($urandom()), $urandom());
      applyStimulus(r, refEncode(r));
    end
    waitDrain();

    $display("[TB] counter saturation");
    applyReset();
    r = makeReq(32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 65535; i++) applyStimulus(r, {1'b1, 32'h0});
    waitDrain();
    checkOutput("sat_reach", {16'd0, bus.illegal_count}, 32'h0000FFFF);
    applyStimulus(r, {1'b1, 32'h0});
    applyStimulus(r, {1'b1, 32'h0});
    waitDrain();
    checkOutput("sat_hold", {16'd0, bus.illegal_count}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
